// File: rtl/register_file.sv
// 32 x 32-bit MIPS-style register file: two combinational read ports, one clocked write port,
// r0 hardwired to zero, and continuous taps on $v0 (r2) and $a0 (r4).
module register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg1_in,
  input  logic [ADDR_W-1:0] reg2_in,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] write_data,
  input  logic              we,
  output logic [DATA_W-1:0] reg1_out,
  output logic [DATA_W-1:0] reg2_out,
  output logic [DATA_W-1:0] v0,
  output logic [DATA_W-1:0] a0
);

  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] IdxZero = '0;
  localparam logic [ADDR_W-1:0] IdxV0   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IdxA0   = ADDR_W'(4);

  logic [DATA_W-1:0] regs_q [Depth];

  logic write_en;

  // Writes to r0 are dropped so the stored r0 stays zero once reset has run.
  assign write_en = we && (rw != IdxZero);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else if (write_en) begin
      regs_q[rw] <= write_data;
    end
  end

  // r0 is forced to zero on the read side too, so it reads 0 even before the first reset.
  // No write bypass: a read of the write target shows the old value until the edge.
  always_comb begin
    reg1_out = (reg1_in == IdxZero) ? '0 : regs_q[reg1_in];
    reg2_out = (reg2_in == IdxZero) ? '0 : regs_q[reg2_in];
    v0       = regs_q[IdxV0];
    a0       = regs_q[IdxA0];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference array tracks writes; expected read values
// are queued on stimulus and compared against the DUT outputs after they settle.
module tb_register_file;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned Depth = 32;

  localparam int PortR1 = 0;
  localparam int PortR2 = 1;
  localparam int PortV0 = 2;
  localparam int PortA0 = 3;

  logic             clk;
  logic             rst;
  logic [AddrW-1:0] reg1_in;
  logic [AddrW-1:0] reg2_in;
  logic [AddrW-1:0] rw;
  logic [DataW-1:0] write_data;
  logic             we;
  logic [DataW-1:0] reg1_out;
  logic [DataW-1:0] reg2_out;
  logic [DataW-1:0] v0;
  logic [DataW-1:0] a0;

  register_file #(
    .DATA_W(DataW),
    .ADDR_W(AddrW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reg1_in   (reg1_in),
    .reg2_in   (reg2_in),
    .rw        (rw),
    .write_data(write_data),
    .we        (we),
    .reg1_out  (reg1_out),
    .reg2_out  (reg2_out),
    .v0        (v0),
    .a0        (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    int               port;
    logic [DataW-1:0] exp;
  } sb_item_t;

  sb_item_t         sb[$];
  logic [DataW-1:0] model [Depth];
  int               n_checks = 0;
  int               n_bad    = 0;

  task automatic check_eq(input string tag, input logic [DataW-1:0] got,
                          input logic [DataW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DataW-1:0] port_val(input int port);
    case (port)
      PortR1:  return reg1_out;
      PortR2:  return reg2_out;
      PortV0:  return v0;
      default: return a0;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int port, input logic [DataW-1:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.port = port;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check_eq(it.tag, port_val(it.port), it.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) model[i] = '0;
  endtask

  // Drive a read of two indices and queue the model's view of every output.
  task automatic read_pair(input string tag, input logic [AddrW-1:0] a, input logic [AddrW-1:0] b);
    @(negedge clk);
    reg1_in = a;
    reg2_in = b;
    #1;
    expect_val({tag, "_r1"}, PortR1, model[a]);
    expect_val({tag, "_r2"}, PortR2, model[b]);
    expect_val({tag, "_v0"}, PortV0, model[2]);
    expect_val({tag, "_a0"}, PortA0, model[4]);
    drain();
  endtask

  // One clock edge with the given control; the model follows the same rules independently.
  task automatic cycle(input logic r, input logic w, input logic [AddrW-1:0] idx,
                       input logic [DataW-1:0] d);
    @(negedge clk);
    rst        = r;
    we         = w;
    rw         = idx;
    write_data = d;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (w && idx != 0) model[idx] = d;
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    we         = 1'b0;
    rw         = '0;
    write_data = '0;
    reg1_in    = '0;
    reg2_in    = '0;

    // r0 must read zero even before any reset.
    #2;
    expect_val("prereset_r1_zero", PortR1, 32'h0);
    expect_val("prereset_r2_zero", PortR2, 32'h0);
    drain();

    // 1. reset then sweep every index on both ports.
    cycle(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < Depth; i++) begin
      @(negedge clk);
      reg1_in = AddrW'(i);
      reg2_in = AddrW'(Depth - 1 - i);
      #1;
      expect_val($sformatf("rst_r1_%0d", i), PortR1, 32'h0);
      expect_val($sformatf("rst_r2_%0d", Depth - 1 - i), PortR2, 32'h0);
      drain();
    end
    expect_val("rst_v0", PortV0, 32'h0);
    expect_val("rst_a0", PortA0, 32'h0);
    drain();

    // 2. write to r0 is discarded.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    reg1_in = 5'd0;
    reg2_in = 5'd0;
    #1;
    expect_val("r0_write_r1", PortR1, 32'h0);
    expect_val("r0_write_r2", PortR2, 32'h0);
    drain();

    // 3. write r2, visible on read port and v0.
    cycle(1'b0, 1'b1, 5'd2, 32'hAAAA_AAAA);
    @(negedge clk);
    reg1_in = 5'd2;
    #1;
    expect_val("w2_r1", PortR1, 32'hAAAA_AAAA);
    expect_val("w2_v0", PortV0, 32'hAAAA_AAAA);
    expect_val("w2_a0", PortA0, 32'h0);
    drain();

    // 4. write r4, visible on port 2 and a0; r2 untouched.
    cycle(1'b0, 1'b1, 5'd4, 32'hBBBB_BBBB);
    @(negedge clk);
    reg1_in = 5'd2;
    reg2_in = 5'd4;
    #1;
    expect_val("w4_r2", PortR2, 32'hBBBB_BBBB);
    expect_val("w4_a0", PortA0, 32'hBBBB_BBBB);
    expect_val("w4_r1_keeps_r2", PortR1, 32'hAAAA_AAAA);
    expect_val("w4_v0", PortV0, 32'hAAAA_AAAA);
    drain();

    // 5. read-during-write to r7: old value before the edge, new value after, no bypass.
    @(negedge clk);
    reg1_in    = 5'd7;
    reg2_in    = 5'd7;
    rw         = 5'd7;
    we         = 1'b1;
    write_data = 32'h1234_5678;
    #1;
    expect_val("rdw_before_r1", PortR1, 32'h0);
    expect_val("rdw_before_r2", PortR2, 32'h0);
    drain();
    @(posedge clk);
    #1;
    expect_val("rdw_after_r1", PortR1, 32'h1234_5678);
    expect_val("rdw_after_r2", PortR2, 32'h1234_5678);
    drain();
    @(negedge clk);
    we         = 1'b0;
    write_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    expect_val("we0_hold_r7", PortR1, 32'h1234_5678);
    drain();
    model[7] = 32'h1234_5678;
    @(negedge clk);

    // Random writes and reads against the reference array.
    for (int n = 0; n < 60; n++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), AddrW'($urandom_range(0, Depth - 1)), $urandom);
      read_pair($sformatf("rnd%0d", n), AddrW'($urandom_range(0, Depth - 1)),
                AddrW'($urandom_range(0, Depth - 1)));
    end

    // 6. reset wins over a simultaneous write.
    cycle(1'b0, 1'b1, 5'd2, 32'h2222_2222);
    cycle(1'b0, 1'b1, 5'd4, 32'h4444_4444);
    cycle(1'b0, 1'b1, 5'd5, 32'h5555_5555);
    read_pair("pre_rst", 5'd5, 5'd4);
    cycle(1'b1, 1'b1, 5'd5, 32'h9999_9999);
    @(negedge clk);
    reg1_in = 5'd2;
    reg2_in = 5'd5;
    #1;
    expect_val("rstwin_r2", PortR1, 32'h0);
    expect_val("rstwin_r5", PortR2, 32'h0);
    expect_val("rstwin_v0", PortV0, 32'h0);
    expect_val("rstwin_a0", PortA0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
